// File: rtl/exu_lsu_pkg.sv
// Shared types and lane helpers for the execute-stage load/store unit.
// Tag widths are sized for the largest supported configuration.
package exu_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic      is_store;
    logic      is_unsigned;
    lsu_size_e size;
  } lsu_op_t;

  localparam int TAG_RD_W  = 8;
  localparam int TAG_OFF_W = 3;

  typedef struct packed {
    logic [TAG_RD_W-1:0]  rd;
    logic                 is_load;
    logic                 is_unsigned;
    lsu_size_e            size;
    logic [TAG_OFF_W-1:0] offset;
    logic                 killed;
  } lsu_tag_t;

  // Low offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(lsu_size_e size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] be_mask(lsu_size_e size, logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  function automatic logic [63:0] replicate(logic [63:0] data, lsu_size_e size);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {8{data[7:0]}};
      SZ_H:    r = {4{data[15:0]}};
      SZ_W:    r = {2{data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] extend(logic [63:0] data, lsu_size_e size, logic is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = is_unsigned ? {56'b0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    r = is_unsigned ? {48'b0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    r = is_unsigned ? {32'b0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exu_lsu_tag_fifo.sv
// In-order tag FIFO for granted bus accesses; head is visible without a pop.
// kill_all_i marks every stored entry killed; a same-cycle push keeps its own tag.
module exu_lsu_tag_fifo
  import exu_lsu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  lsu_tag_t push_tag_i,
  input  logic     pop_i,
  output lsu_tag_t pop_tag_o,
  input  logic     kill_all_i,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_tag_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (r_wptr == PTR_W'(i))) r_mem[i] <= push_tag_i;
        else if (kill_all_i)                 r_mem[i].killed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= ptr_inc(r_wptr);
      if (pop_i)  r_rptr <= ptr_inc(r_rptr);
      if (push_i && !pop_i)      r_count <= r_count + 1'b1;
      else if (pop_i && !push_i) r_count <= r_count - 1'b1;
    end
  end

  assign pop_tag_o = r_mem[r_rptr];
  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);

endmodule

// File: rtl/exu_lsu_pipe.sv
// Pipelined load/store unit: one-entry issue register in front of an OBI-style
// bus, in-order tag tracking of granted accesses, and a registered writeback.
module exu_lsu_pipe
  import exu_lsu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  lsu_op_t               lsu_op_i,
  input  logic [ADDR_W-1:0]     lsu_addr_i,
  input  logic [DATA_W-1:0]     lsu_wdata_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  misaligned_o,
  output logic [ADDR_W-1:0]     bad_addr_o,
  output logic                  idle_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  r_issue_valid;
  logic                  r_issue_killed;
  lsu_op_t               r_issue_op;
  logic [OFF_W-1:0]      r_issue_off;
  logic [REG_ADDR_W-1:0] r_issue_rd;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_we;
  logic [BE_W-1:0]       r_mem_be;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_mis;
  logic [ADDR_W-1:0]     r_bad_addr;

  logic [OFF_W-1:0]      w_offset;
  logic                  w_misaligned;
  logic                  w_room;
  logic                  w_accept;
  logic                  w_accept_issue;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_resp;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  lsu_tag_t              w_push_tag;
  lsu_tag_t              w_pop_tag;
  logic [DATA_W-1:0]     w_shifted;
  logic [DATA_W-1:0]     w_ext;
  logic                  w_wb_set;

  assign w_offset = lsu_addr_i[OFF_W-1:0];

  // Doubleword accesses have no lane on a 32-bit bus, so they fault like misalignment.
  assign w_misaligned = ((3'(w_offset) & align_mask(lsu_op_i.size)) != 3'b000) ||
                        ((lsu_op_i.size == SZ_D) && (DATA_W < 64));

  // The issue entry counts against the budget until it is granted into the FIFO.
  assign w_room      = (32'(r_cnt) + 32'(r_issue_valid)) < 32'(MAX_OUTSTANDING);
  assign lsu_ready_o = (~r_issue_valid | mem_gnt_i) & w_room & ~flush_i;

  assign w_accept       = lsu_valid_i & lsu_ready_o;
  assign w_accept_issue = w_accept & ~w_misaligned;
  assign w_grant        = r_issue_valid & mem_gnt_i;
  assign w_push         = w_grant & ~w_fifo_full;
  assign w_resp         = mem_rvalid_i & (r_cnt != '0) & ~w_fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid  <= 1'b0;
      r_issue_killed <= 1'b0;
      r_issue_op     <= '0;
      r_issue_off    <= '0;
      r_issue_rd     <= '0;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_be       <= '0;
      r_mem_wdata    <= '0;
    end else if (w_accept_issue) begin
      r_issue_valid  <= 1'b1;
      r_issue_killed <= 1'b0;
      r_issue_op     <= lsu_op_i;
      r_issue_off    <= w_offset;
      r_issue_rd     <= lsu_rd_i;
      r_mem_addr     <= {lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_mem_we       <= lsu_op_i.is_store;
      r_mem_be       <= BE_W'(be_mask(lsu_op_i.size, 3'(w_offset)));
      r_mem_wdata    <= DATA_W'(replicate(64'(lsu_wdata_i), lsu_op_i.size));
    end else begin
      if (w_grant) r_issue_valid  <= 1'b0;
      if (flush_i) r_issue_killed <= 1'b1;
    end
  end

  assign mem_req_o   = r_issue_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;

  // A flush in the grant cycle must also reach the entry being pushed.
  always_comb begin
    w_push_tag             = '0;
    w_push_tag.rd          = TAG_RD_W'(r_issue_rd);
    w_push_tag.is_load     = ~r_issue_op.is_store;
    w_push_tag.is_unsigned = r_issue_op.is_unsigned;
    w_push_tag.size        = r_issue_op.size;
    w_push_tag.offset      = TAG_OFF_W'(r_issue_off);
    w_push_tag.killed      = r_issue_killed | flush_i;
  end

  exu_lsu_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (w_push),
    .push_tag_i(w_push_tag),
    .pop_i     (w_resp),
    .pop_tag_o (w_pop_tag),
    .kill_all_i(flush_i),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_push, w_resp})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_shifted = mem_rdata_i >> {w_pop_tag.offset, 3'b000};
  assign w_ext     = DATA_W'(extend(64'(w_shifted), w_pop_tag.size, w_pop_tag.is_unsigned));
  assign w_wb_set  = w_resp & w_pop_tag.is_load & ~w_pop_tag.killed & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_mis      <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_wb_valid <= w_wb_set;
      if (w_wb_set) begin
        r_wb_rd   <= REG_ADDR_W'(w_pop_tag.rd);
        r_wb_data <= w_ext;
      end
      r_mis <= w_accept & w_misaligned;
      if (w_accept && w_misaligned) r_bad_addr <= lsu_addr_i;
    end
  end

  // A writeback already registered is dropped if a flush lands in its cycle.
  assign wb_valid_o   = r_wb_valid & ~flush_i;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign misaligned_o = r_mis;
  assign bad_addr_o   = r_bad_addr;
  assign idle_o       = ~r_issue_valid & (r_cnt == '0) & ~wb_valid_o;

endmodule

// File: tb/tb_exu_lsu_pipe.sv
// Scoreboard bench for exu_lsu_pipe: a driver issues commands and plays the bus,
// a monitor compares DUT outputs against queued expectations each cycle.
module tb_exu_lsu_pipe;
  import exu_lsu_pkg::*;

  localparam int MAX_OUT    = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  lsu_valid_i, lsu_ready_o;
  lsu_op_t               lsu_op_i;
  logic [ADDR_W-1:0]     lsu_addr_i;
  logic [DATA_W-1:0]     lsu_wdata_i;
  logic [REG_ADDR_W-1:0] lsu_rd_i;
  logic                  flush_i;
  logic                  mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [DATA_W-1:0]     mem_wdata_o, mem_rdata_i;
  logic                  wb_valid_o, misaligned_o, idle_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [DATA_W-1:0]     wb_data_o;
  logic [ADDR_W-1:0]     bad_addr_o;

  always #5 clk = ~clk;

  exu_lsu_pipe #(
    .MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_op_i(lsu_op_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rd_i(lsu_rd_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misaligned_o(misaligned_o), .bad_addr_o(bad_addr_o), .idle_o(idle_o)
  );

  typedef struct {
    bit          st;
    bit          uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    bit          killed;
  } cmd_t;
  typedef struct { logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { int due; logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { int due; logic [31:0] addr; } mis_t;

  cmd_t cmd_q[$];
  cmd_t inflight[$];   // accepted, aligned, not yet responded; oldest first
  bus_t bus_exp[$];
  wb_t  wb_exp[$];
  mis_t mis_exp[$];

  cmd_t cur;
  bit   cur_valid = 0;
  bit   iss_pend = 0;
  int   out_cnt = 0;
  int   valid_prob = 100, gnt_prob = 100, rv_prob = 100, flush_prob = 0;
  bit   force_flush = 0;
  bit   mon_en = 0;
  int   errors = 0, checks = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, act, req_v, cyc);
    end
  endtask

  // Reference model: natural alignment, byte lanes and extension from first principles.
  function automatic bit is_mis(cmd_t c);
    return (c.addr % (32'd1 << c.sz)) != 0;
  endfunction

  function automatic bus_t bus_of(cmd_t c);
    bus_t b;
    longint unsigned nb   = 64'd1 << c.sz;
    longint unsigned off  = 64'(c.addr % 4);
    longint unsigned lane = (64'd1 << (8 * nb)) - 1;
    longint unsigned w    = 0;
    b.addr = c.addr & ~32'h3;
    b.we   = c.st;
    b.be   = 4'(((64'd1 << nb) - 1) << off);
    for (int k = 0; k < 4 / int'(nb); k++) w |= (64'(c.wdata) & lane) << (8 * nb * 64'(k));
    b.wdata = w[31:0];
    return b;
  endfunction

  function automatic logic [31:0] load_val(cmd_t c);
    longint unsigned nbits = 8 * (64'd1 << c.sz);
    longint unsigned off   = 64'(c.addr % 4);
    longint unsigned mask  = (64'd1 << nbits) - 1;
    longint unsigned v     = (64'(c.rdata) >> (8 * off)) & mask;
    if (!c.uns && (((v >> (nbits - 1)) & 64'd1) != 0)) v |= ~mask;
    return v[31:0];
  endfunction

  task automatic add_cmd(bit st, bit uns, logic [1:0] sz, logic [31:0] addr,
                         logic [31:0] wdata, logic [31:0] rdata, logic [4:0] rd);
    cmd_t c;
    c = '{st, uns, sz, addr, wdata, rdata, rd, 1'b0};
    cmd_q.push_back(c);
  endtask

  // One clock of stimulus plus model update after the DUT has settled.
  task automatic step();
    bit   rv, fl;
    cmd_t e;
    @(posedge clk); #1;
    if (!cur_valid && cmd_q.size() > 0 && $urandom_range(99) < valid_prob) begin
      cur = cmd_q.pop_front();
      cur_valid = 1;
    end
    lsu_valid_i          = cur_valid;
    lsu_op_i.is_store    = cur.st;
    lsu_op_i.is_unsigned = cur.uns;
    lsu_op_i.size        = lsu_size_e'(cur.sz);
    lsu_addr_i           = cur.addr;
    lsu_wdata_i          = cur.wdata;
    lsu_rd_i             = cur.rd;
    mem_gnt_i            = ($urandom_range(99) < gnt_prob);
    rv                   = ($urandom_range(99) < rv_prob);
    mem_rvalid_i         = rv;
    mem_rdata_i          = (out_cnt > 0) ? inflight[0].rdata : $urandom();
    fl = force_flush ||
         (($urandom_range(99) < flush_prob) && !(iss_pend && inflight[$].st));
    flush_i = fl;
    if (fl) begin
      foreach (inflight[i]) inflight[i].killed = 1;
      for (int i = wb_exp.size() - 1; i >= 0; i--)
        if (wb_exp[i].due == cyc) wb_exp.delete(i);
    end
    @(negedge clk); #1;
    if (rv && out_cnt > 0) begin
      e = inflight.pop_front();
      out_cnt--;
      if (!e.st && !e.killed) wb_exp.push_back('{cyc + 1, e.rd, load_val(e)});
    end
    if (iss_pend && mem_gnt_i) begin
      iss_pend = 0;
      out_cnt++;
    end
    if (lsu_valid_i && lsu_ready_o) begin
      cur_valid = 0;
      if (is_mis(cur)) mis_exp.push_back('{cyc + 1, cur.addr});
      else begin
        bus_exp.push_back(bus_of(cur));
        inflight.push_back(cur);
        iss_pend = 1;
      end
    end
  endtask

  task automatic drain(string name, int limit);
    int n = 0;
    while ((cmd_q.size() > 0 || cur_valid || iss_pend || out_cnt > 0 ||
            wb_exp.size() > 0 || mis_exp.size() > 0) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
    end
    repeat (2) step();
  endtask

  // Monitor: compares every DUT output against the scoreboard once per cycle.
  initial begin
    bus_t b;
    wb_t  w;
    mis_t m;
    bit   exp_wb, exp_mis;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ready", 64'(lsu_ready_o),
            64'((!iss_pend || mem_gnt_i) && (out_cnt + int'(iss_pend) < MAX_OUT) && !flush_i));
        chk("req", 64'(mem_req_o), 64'(iss_pend));
        if (iss_pend && bus_exp.size() > 0) begin
          b = bus_exp[0];
          chk("mem_addr", 64'(mem_addr_o), 64'(b.addr));
          chk("mem_we", 64'(mem_we_o), 64'(b.we));
          chk("mem_be", 64'(mem_be_o), 64'(b.be));
          if (b.we) chk("mem_wdata", 64'(mem_wdata_o), 64'(b.wdata));
          if (mem_gnt_i) begin
            void'(bus_exp.pop_front());
            $display("[%0d] bus addr=%h we=%0d be=%b wdata=%h", cyc, b.addr, b.we, b.be, b.wdata);
          end
        end
        exp_wb = (wb_exp.size() > 0) && (wb_exp[0].due == cyc);
        chk("wb_valid", 64'(wb_valid_o), 64'(exp_wb));
        if (exp_wb) begin
          w = wb_exp.pop_front();
          if (wb_valid_o) begin
            chk("wb_rd", 64'(wb_rd_o), 64'(w.rd));
            chk("wb_data", 64'(wb_data_o), 64'(w.data));
            $display("[%0d] wb rd=%0d data=%h", cyc, wb_rd_o, wb_data_o);
          end
        end
        exp_mis = (mis_exp.size() > 0) && (mis_exp[0].due == cyc);
        chk("misaligned", 64'(misaligned_o), 64'(exp_mis));
        if (exp_mis) begin
          m = mis_exp.pop_front();
          if (misaligned_o) begin
            chk("bad_addr", 64'(bad_addr_o), 64'(m.addr));
            $display("[%0d] misaligned addr=%h", cyc, bad_addr_o);
          end
        end
        chk("idle", 64'(idle_o), 64'(!iss_pend && out_cnt == 0 && !exp_wb));
      end
    end
  end

  initial begin
    int n;
    lsu_valid_i = 0; lsu_op_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_rd_i = '0;
    flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    cur = '{0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(lsu_ready_o), 64'd1);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_be", 64'(mem_be_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_misaligned", 64'(misaligned_o), 64'd0);
    @(posedge clk); #2;
    rst_n = 1;
    mon_en = 1;

    // Directed accesses with immediate grant and response.
    add_cmd(0, 0, 2'd2, 32'h1000, 32'h0,    32'hDEADBEEF, 5'd1);  // LW
    add_cmd(0, 0, 2'd0, 32'h1003, 32'h0,    32'h80FFFFFF, 5'd2);  // LB
    add_cmd(0, 1, 2'd0, 32'h1003, 32'h0,    32'h80FFFFFF, 5'd3);  // LBU
    add_cmd(1, 0, 2'd1, 32'h1002, 32'h1234, 32'h0,        5'd0);  // SH
    add_cmd(0, 0, 2'd2, 32'h1001, 32'h0,    32'h0,        5'd4);  // LW misaligned
    add_cmd(0, 1, 2'd1, 32'h1006, 32'h0,    32'h8001_1234, 5'd5); // LHU
    drain("directed", 200);

    // Outstanding limit: grants flow, responses held off.
    rv_prob = 0;
    for (int i = 0; i < 4; i++)
      add_cmd(0, 0, 2'd2, 32'h3000 + 32'(4 * i), 32'h0, $urandom(), 5'(10 + i));
    repeat (8) step();
    rv_prob = 100;
    drain("max_out", 200);

    // Flush with two loads in flight: bus completes, no writeback.
    rv_prob = 0;
    add_cmd(0, 0, 2'd2, 32'h4000, 32'h0, 32'h11111111, 5'd20);
    add_cmd(0, 0, 2'd1, 32'h4006, 32'h0, 32'h22222222, 5'd21);
    n = 0;
    while (out_cnt < 2 && n < 20) begin
      step();
      n++;
    end
    chk("flush_setup_outstanding", 64'(out_cnt), 64'd2);
    force_flush = 1;
    step();
    force_flush = 0;
    rv_prob = 100;
    drain("flush", 200);

    // Randomized traffic with stalls, protocol-error responses and flushes.
    for (int i = 0; i < 300; i++)
      add_cmd($urandom_range(1), $urandom_range(1), 2'($urandom_range(2)),
              32'h2000 + 32'($urandom_range(15)), $urandom(), $urandom(), 5'($urandom_range(31)));
    valid_prob = 70; gnt_prob = 60; rv_prob = 50; flush_prob = 3;
    drain("random", 6000);
    valid_prob = 100; gnt_prob = 100; rv_prob = 80; flush_prob = 0;
    drain("final", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
